// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial link. Both the transmitter and the
// receiver import this package.
//   tx_state_e  : frame sequencer states (IDLE, START, DATA, STOP)
//   *_LEVEL     : line levels for idle, start bit and stop bit
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Down-counter that measures one serial bit period. A load restarts the count
// at CLKS_PER_BIT-1. The counter then runs down to 0 and stays there.
// tick_o is high while the count is 0, which marks the last clock of a bit.
// With CLKS_PER_BIT=1 the load value is 0, so tick_o stays high and every
// bit lasts exactly one clock.
// Ports:
//   clk     : clock, posedge
//   reset   : synchronous, active-high; clears the count
//   load_i  : restart the bit period
//   tick_o  : final cycle of the current bit period
// -----------------------------------------------------------------------------
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, count down, or hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != CNT_W'(0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_W'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_W'(0));

endmodule

// File: rtl/par2ser_tx.sv
// -----------------------------------------------------------------------------
// par2ser_tx
// Parallel-in / serial-out framed transmitter. The module takes one DATA_W-bit
// word over a valid/ready handshake and sends it as one frame:
// start bit (0), DATA_W data bits, then stop bit (1). Each bit lasts
// CLKS_PER_BIT clocks. The line is high when idle.
// Every output comes directly from a flop.
// Ports:
//   clk      : clock, posedge
//   reset    : synchronous, active-high; aborts any frame in progress
//   data_i   : word to send; captured only on the accept cycle
//   valid_i  : data_i is valid
//   ready_o  : a word can be accepted this cycle (IDLE only)
//   serial_o : serial line
//   busy_o   : a frame is in progress
//   done_o   : one-cycle pulse in the first IDLE cycle after a stop bit
// -----------------------------------------------------------------------------
module par2ser_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned LSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              serial_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned IDX_W = $clog2(DATA_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    // Returns the bit that goes on the line next. The shift register always
    // keeps the outgoing bit at the end it shifts out from.
    function automatic logic head_bit(input logic [DATA_W-1:0] word);
        if (LSB_FIRST != 0) begin
            return word[0];
        end else begin
            return word[DATA_W-1];
        end
    endfunction

    tx_state_e         state_q,   state_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              serial_q,  serial_d;
    logic              busy_q,    busy_d;
    logic              ready_q,   ready_d;
    logic              done_q,    done_d;

    logic              tick_s;
    logic              load_s;
    logic [DATA_W-1:0] shifted_s;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (load_s),
        .tick_o (tick_s)
    );

    // Frame sequencer. The registered outputs are computed from the next
    // state, so the line changes on the edge that enters each bit.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        load_s    = 1'b0;
        if (LSB_FIRST != 0) begin
            shifted_s = shreg_q >> 1;
        end else begin
            shifted_s = shreg_q << 1;
        end

        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    state_d  = START;
                    shreg_d  = data_i;
                    serial_d = START_LEVEL;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    load_s   = 1'b1;
                end else begin
                    serial_d = IDLE_LEVEL;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d   = DATA;
                    bit_idx_d = IDX_W'(0);
                    serial_d  = head_bit(shreg_q);
                    load_s    = 1'b1;
                end else begin
                    serial_d = START_LEVEL;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d  = STOP;
                        serial_d = STOP_LEVEL;
                        load_s   = 1'b1;
                    end else begin
                        shreg_d   = shifted_s;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        serial_d  = head_bit(shifted_s);
                        load_s    = 1'b1;
                    end
                end else begin
                    serial_d = serial_q;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_d  = IDLE;
                    serial_d = IDLE_LEVEL;
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    serial_d = STOP_LEVEL;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = IDLE_LEVEL;
                busy_d   = 1'b0;
                ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers. A reset aborts any frame and drops the
    // captured word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= {DATA_W{1'b0}};
            bit_idx_q <= IDX_W'(0);
            serial_q  <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign ready_o  = ready_q;
    assign serial_o = serial_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_par2ser_tx.sv
// -----------------------------------------------------------------------------
// tb_par2ser_tx
// Directed bench with two transmitter instances:
//   dut_a : DATA_W=8, CLKS_PER_BIT=4, LSB first
//   dut_b : DATA_W=8, CLKS_PER_BIT=1, MSB first
// Inputs are driven and outputs are sampled on the falling edge.
// "cycle k" means the sample taken after the k-th rising edge that follows
// an accept.
// -----------------------------------------------------------------------------
module tb_par2ser_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, serial_a, busy_a, done_a;
    logic       ready_b, serial_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    par2ser_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .data_i   (data_a),
        .valid_i  (valid_a),
        .ready_o  (ready_a),
        .serial_o (serial_a),
        .busy_o   (busy_a),
        .done_o   (done_a)
    );

    par2ser_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .LSB_FIRST(0)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .data_i   (data_b),
        .valid_i  (valid_b),
        .ready_o  (ready_b),
        .serial_o (serial_b),
        .busy_o   (busy_b),
        .done_o   (done_b)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame slot idx (0=start, 1..8=data, 9=stop).
    function automatic logic frame_bit(input logic [7:0] d, input int idx, input bit lsb);
        if (idx == 0)      return 1'b0;
        else if (idx == 9) return 1'b1;
        else if (lsb)      return d[idx-1];
        else               return d[8-idx];
    endfunction

    // Starts at cycle 1 of a dut_a frame. Returns at cycle 41, the done cycle.
    // With disturb set, valid_a and data_a change during the frame.
    task automatic check_frame_a(input string tag, input logic [7:0] d, input bit disturb);
        for (int k = 1; k <= 40; k++) begin
            check_value($sformatf("%s serial c%0d", tag, k), 32'(serial_a), 32'(frame_bit(d, (k-1)/4, 1'b1)));
            check_value($sformatf("%s busy c%0d", tag, k), 32'(busy_a), 32'd1);
            check_value($sformatf("%s ready c%0d", tag, k), 32'(ready_a), 32'd0);
            check_value($sformatf("%s done c%0d", tag, k), 32'(done_a), 32'd0);
            if (disturb) begin
                if (k >= 5 && k <= 35) begin
                    valid_a = k[0];
                    data_a  = 8'(k * 37);
                end else begin
                    valid_a = 1'b0;
                end
            end
            @(negedge clk);
        end
        check_value({tag, " done c41"},   32'(done_a),   32'd1);
        check_value({tag, " ready c41"},  32'(ready_a),  32'd1);
        check_value({tag, " busy c41"},   32'(busy_a),   32'd0);
        check_value({tag, " serial c41"}, 32'(serial_a), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;

        // Reset held for 3 cycles, then 20 idle cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("rst serial_a", 32'(serial_a), 32'd1);
            check_value("rst ready_a",  32'(ready_a),  32'd1);
            check_value("rst busy_a",   32'(busy_a),   32'd0);
            check_value("rst done_a",   32'(done_a),   32'd0);
            check_value("rst serial_b", 32'(serial_b), 32'd1);
            check_value("rst ready_b",  32'(ready_b),  32'd1);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_value("idle serial", 32'(serial_a), 32'd1);
            check_value("idle ready",  32'(ready_a),  32'd1);
            check_value("idle busy",   32'(busy_a),   32'd0);
        end

        // Single frame of 8'hA5, LSB first.
        data_a  = 8'hA5;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check_frame_a("a5", 8'hA5, 1'b0);
        @(negedge clk);
        check_value("a5 done c42",   32'(done_a),   32'd0);
        check_value("a5 serial c42", 32'(serial_a), 32'd1);
        repeat (3) @(negedge clk);

        // Back-to-back: valid held high, 8'h00 then 8'hFF.
        data_a  = 8'h00;
        valid_a = 1'b1;
        @(negedge clk);
        data_a = 8'hFF;
        check_frame_a("b2b0", 8'h00, 1'b0);
        @(negedge clk);
        valid_a = 1'b0;
        check_frame_a("b2b1", 8'hFF, 1'b0);
        repeat (3) @(negedge clk);

        // Inputs that change during a frame must not affect it.
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check_frame_a("ign", 8'h3C, 1'b1);
        repeat (3) @(negedge clk);

        // MSB first with one clock per bit: 8'h80.
        data_b  = 8'h80;
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check_value($sformatf("msb serial c%0d", k), 32'(serial_b), 32'(frame_bit(8'h80, k-1, 1'b0)));
            check_value($sformatf("msb busy c%0d", k),   32'(busy_b),   32'd1);
            check_value($sformatf("msb done c%0d", k),   32'(done_b),   32'd0);
            @(negedge clk);
        end
        check_value("msb done c11",  32'(done_b),  32'd1);
        check_value("msb ready c11", 32'(ready_b), 32'd1);
        check_value("msb busy c11",  32'(busy_b),  32'd0);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 (frame slot 4, cycles 17..20).
        data_a  = 8'hC3;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        for (int k = 1; k < 18; k++) @(negedge clk);
        check_value("mid busy before rst", 32'(busy_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_value("mid serial", 32'(serial_a), 32'd1);
        check_value("mid ready",  32'(ready_a),  32'd1);
        check_value("mid busy",   32'(busy_a),   32'd0);
        for (int k = 0; k < 45; k++) begin
            check_value($sformatf("mid no done %0d", k), 32'(done_a), 32'd0);
            check_value($sformatf("mid line %0d", k),    32'(serial_a), 32'd1);
            @(negedge clk);
        end
        data_a  = 8'h5A;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check_frame_a("post", 8'h5A, 1'b0);
        repeat (2) @(negedge clk);

        // Reset together with valid: no word is accepted.
        data_a  = 8'h77;
        valid_a = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        reset   = 1'b0;
        check_value("rstv ready", 32'(ready_a), 32'd1);
        check_value("rstv busy",  32'(busy_a),  32'd0);
        @(negedge clk);
        check_value("rstv serial", 32'(serial_a), 32'd1);
        check_value("rstv busy2",  32'(busy_a),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
